rf_bist: RTL and testbench

RF_BIST -- requirements
Module: rf_bist

---
 rtl/rf_bist.sv | 186 ++++++++++++++++++
 tb/tb_rf_bist.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_bist.sv
// rf_bist: 8x8 register-file BIST, LFSR write sweeps checked against a shadow copy.
// Define RF_BIST_ERRLOG_EN to keep a log of the first failing register in each run.
module rf_bist #(
    parameter int unsigned PASSES = 4,
    parameter logic [7:0]  SEED   = 8'hA5
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic       WEN,
    output logic [2:0] RW,
    output logic [7:0] busW,
    output logic [2:0] RX,
    output logic [2:0] RY,
    input  logic [7:0] busX,
    input  logic [7:0] busY,
    output logic [2:0] fail_reg,
    output logic [7:0] fail_exp,
    output logic [7:0] fail_act
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [5:0] LAST_PASS = 6'(PASSES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [5:0] pcnt_q, pcnt_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic [7:0] shadow_q [8];

    logic       in_write;
    logic       in_read;
    logic       start_run;
    logic [2:0] ry_addr;
    logic [7:0] exp_x;
    logic [7:0] exp_y;
    logic       mis_x;
    logic       mis_y;
    logic [8:0] err_sum;

    assign in_write  = (state_q == S_WRITE);
    assign in_read   = (state_q == S_READ);
    assign start_run = (state_q == S_IDLE) && start;
    assign ry_addr   = 3'd7 - k_q;

    // Register 0 is hard-wired to zero in the register file.
    assign exp_x = (k_q == 3'd0) ? 8'h00 : shadow_q[k_q];
    assign exp_y = (ry_addr == 3'd0) ? 8'h00 : shadow_q[ry_addr];
    assign mis_x = in_read && (busX != exp_x);
    assign mis_y = in_read && (busY != exp_y);
    assign err_sum = {1'b0, err_q} + {8'd0, mis_x} + {8'd0, mis_y};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pcnt_d  = pcnt_q;
        lfsr_d  = lfsr_q;
        err_d   = err_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WRITE;
                    k_d     = 3'd0;
                    pcnt_d  = 6'd0;
                    lfsr_d  = SEED_EFF;
                    err_d   = 8'h00;
                    pass_d  = 1'b0;
                end
            end
            S_WRITE: begin
                lfsr_d = {lfsr_q[6:0],
                          lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                k_d    = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
                k_d   = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    if (pcnt_q == LAST_PASS) begin
                        state_d = S_DONE;
                        pass_d  = (err_d == 8'h00);
                    end else begin
                        state_d = S_WRITE;
                        pcnt_d  = pcnt_q + 6'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            k_q     <= 3'd0;
            pcnt_q  <= 6'd0;
            lfsr_q  <= 8'h00;
            err_q   <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pcnt_q  <= pcnt_d;
            lfsr_q  <= lfsr_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 8'h00;
            end
        end else if (in_write) begin
            shadow_q[k_q] <= lfsr_q;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign WEN     = in_write;
    assign RW      = in_write ? k_q : 3'd0;
    assign busW    = in_write ? lfsr_q : 8'h00;
    assign RX      = in_read ? k_q : 3'd0;
    assign RY      = in_read ? ry_addr : 3'd0;

`ifdef RF_BIST_ERRLOG_EN
    logic       flog_q;
    logic [2:0] freg_q;
    logic [7:0] fexp_q;
    logic [7:0] fact_q;

    // X is examined before Y so a double miss logs the X register.
    always_ff @(posedge Clk) begin
        if (Rst || start_run) begin
            flog_q <= 1'b0;
            freg_q <= 3'd0;
            fexp_q <= 8'h00;
            fact_q <= 8'h00;
        end else if (!flog_q && mis_x) begin
            flog_q <= 1'b1;
            freg_q <= k_q;
            fexp_q <= exp_x;
            fact_q <= busX;
        end else if (!flog_q && mis_y) begin
            flog_q <= 1'b1;
            freg_q <= ry_addr;
            fexp_q <= exp_y;
            fact_q <= busY;
        end
    end

    assign fail_reg = freg_q;
    assign fail_exp = fexp_q;
    assign fail_act = fact_q;
`else
    assign fail_reg = 3'd0;
    assign fail_exp = 8'h00;
    assign fail_act = 8'h00;
`endif

endmodule

// File: tb/tb_rf_bist.sv
// tb_rf_bist: scoreboard bench driving rf_bist instances with PASSES 4, 1 and 63.
// Define RF_BIST_ERRLOG_EN in both RTL and bench builds to check the failure log.
module tb_rf_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // 0 good, 1 reg3 bit7 flipped, 2 reg0 stores writes, 3 every read corrupted
    logic [1:0] mode = 2'd0;

    logic [2:0]      rst;
    logic [2:0]      start;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic [2:0]      pass;
    logic [2:0]      wen;
    logic [2:0][7:0] err;
    logic [2:0][7:0] busw;
    logic [2:0][7:0] bx;
    logic [2:0][7:0] by;
    logic [2:0][7:0] fexp;
    logic [2:0][7:0] fact;
    logic [2:0][2:0] rw;
    logic [2:0][2:0] rx;
    logic [2:0][2:0] ry;
    logic [2:0][2:0] freg;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] err;
        logic       pass;
        logic [2:0] freg;
        logic [7:0] fexp;
        logic [7:0] fact;
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] nx(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [7:0] rd(input logic [1:0] md,
                                      input logic [2:0] a,
                                      input logic [7:0] v);
        logic [7:0] good;
        good = (a == 3'd0) ? 8'h00 : v;
        case (md)
            2'd0:    rd = good;
            2'd1:    rd = (a == 3'd3) ? (v ^ 8'h80) : good;
            2'd2:    rd = v;
            default: rd = good ^ 8'h01;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_u
        localparam int P = (g == 0) ? 4 : (g == 1) ? 1 : 63;
        logic [7:0] rf [8];

        rf_bist #(.PASSES(P), .SEED(8'hA5)) u_dut (
            .Clk(clk), .Rst(rst[g]), .start(start[g]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .err_cnt(err[g]), .WEN(wen[g]), .RW(rw[g]),
            .busW(busw[g]), .RX(rx[g]), .RY(ry[g]),
            .busX(bx[g]), .busY(by[g]), .fail_reg(freg[g]),
            .fail_exp(fexp[g]), .fail_act(fact[g])
        );

        always @(posedge clk) if (wen[g]) rf[rw[g]] <= busw[g];
        assign bx[g] = rd(mode, rx[g], rf[rx[g]]);
        assign by[g] = rd(mode, ry[g], rf[ry[g]]);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                if (sbq.size() == 0) begin
                    check("sb_underflow", 32'(sbq.size()), 32'd1);
                end else begin
                    e_mon = sbq.pop_front();
                    check("sb_inst", 32'(i), 32'(e_mon.inst));
                    check("sb_err", 32'(err[i]), 32'(e_mon.err));
                    check("sb_pass", 32'(pass[i]), 32'(e_mon.pass));
                    check("sb_freg", 32'(freg[i]), 32'(e_mon.freg));
                    check("sb_fexp", 32'(fexp[i]), 32'(e_mon.fexp));
                    check("sb_fact", 32'(fact[i]), 32'(e_mon.fact));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int gi, input int p, input logic [1:0] md,
                            output logic [7:0] e_err);
        exp_t       e;
        logic [7:0] l;
        logic [7:0] w [8];
        l = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            w[k] = l;
            l = nx(l);
        end
        e.inst = 2'(gi);
        case (md)
            2'd0: begin
                e.err = 8'h00; e.freg = 3'd0; e.fexp = 8'h00; e.fact = 8'h00;
            end
            2'd1: begin
                e.err = 8'(2 * p); e.freg = 3'd3;
                e.fexp = w[3]; e.fact = w[3] ^ 8'h80;
            end
            2'd2: begin
                e.err = 8'(2 * p); e.freg = 3'd0;
                e.fexp = 8'h00; e.fact = w[0];
            end
            default: begin
                e.err = (16 * p > 255) ? 8'hFF : 8'(16 * p);
                e.freg = 3'd0; e.fexp = 8'h00; e.fact = 8'h01;
            end
        endcase
        e.pass = (e.err == 8'h00);
`ifndef RF_BIST_ERRLOG_EN
        e.freg = 3'd0;
        e.fexp = 8'h00;
        e.fact = 8'h00;
`endif
        e_err = e.err;
        sbq.push_back(e);
    endtask

    task automatic run(input int gi, input int p, input logic [1:0] md);
        logic [7:0] l;
        logic [7:0] e_err;
        int         bad, ph, kk;
        bit         seen, act, w, r;
        mode = md;
        start[gi] = 1'b1;
        push_exp(gi, p, md, e_err);
        tick();
        start[gi] = 1'b0;
        l = 8'hA5;
        bad = 0;
        seen = 1'b0;
        for (int c = 1; c <= p * 16 + 40 && !seen; c++) begin
            ph  = (c - 1) % 16;
            kk  = ph % 8;
            act = (c <= p * 16);
            w   = act && (ph < 8);
            r   = act && (ph >= 8);
            if (wen[gi] !== w) bad++;
            if (rw[gi] !== (w ? 3'(kk) : 3'd0)) bad++;
            if (busw[gi] !== (w ? l : 8'h00)) bad++;
            if (rx[gi] !== (r ? 3'(kk) : 3'd0)) bad++;
            if (ry[gi] !== (r ? 3'(7 - kk) : 3'd0)) bad++;
            if (busy[gi] !== (c <= p * 16 + 1)) bad++;
            if (done[gi] !== (c == p * 16 + 1)) bad++;
            if (c <= 8 && err[gi] !== 8'h00) bad++;
            if (w) l = nx(l);
            if (done[gi] === 1'b1) begin
                seen = 1'b1;
                check("done_cycle", 32'(c), 32'(p * 16 + 1));
            end
            tick();
        end
        check("done_seen", 32'(seen), 32'd1);
        check("run_seq", 32'(bad), 32'd0);
        repeat (3) tick();
        check("idle_busy", 32'(busy[gi]), 32'd0);
        check("hold_err", 32'(err[gi]), 32'(e_err));
        check("hold_pass", 32'(pass[gi]), 32'(e_err == 8'h00));
    endtask

    initial begin
        logic [7:0] dummy;
        int         dn, bad, t18;
        rst = 3'b111;
        start = 3'b000;
        repeat (3) tick();
        rst = 3'b000;
        for (int i = 0; i < 3; i++) begin
            check("rst_outs", 32'({busy[i], done[i], pass[i], err[i], wen[i],
                                   rw[i], busw[i], rx[i], ry[i]}), 32'd0);
            check("rst_flog", 32'({freg[i], fexp[i], fact[i]}), 32'd0);
        end

        run(0, 4, 2'd0);
        run(0, 4, 2'd1);
        run(0, 4, 2'd0);
        run(1, 1, 2'd2);

        // abort in the second READ sweep, then a clean run
        mode = 2'd0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (25) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_wen", 32'(wen[0]), 32'd0);
        check("abort_err", 32'(err[0]), 32'd0);
        dn = 0;
        for (int i = 0; i < 70; i++) begin
            if (done[0] === 1'b1) dn++;
            tick();
        end
        check("abort_no_done", 32'(dn), 32'd0);
        run(0, 4, 2'd0);

        rst[1] = 1'b1;
        start[1] = 1'b1;
        tick();
        check("rst_prio_busy", 32'(busy[1]), 32'd0);
        rst[1] = 1'b0;
        start[1] = 1'b0;
        tick();
        check("rst_prio_idle", 32'(busy[1]), 32'd0);

        // start held high: runs back to back, one IDLE cycle between them
        for (int i = 0; i < 12; i++) push_exp(1, 1, 2'd0, dummy);
        start[1] = 1'b1;
        dn = 0;
        bad = 0;
        for (int t = 0; t < 200; t++) begin
            t18 = t % 18;
            if (wen[1] !== (t18 >= 1 && t18 <= 8)) bad++;
            if (done[1] !== (t18 == 17)) bad++;
            if (done[1] === 1'b1) dn++;
            tick();
        end
        start[1] = 1'b0;
        check("held_seq", 32'(bad), 32'd0);
        check("held_dones", 32'(dn), 32'd11);
        for (int i = 0; i < 40 && busy[1] === 1'b1; i++) tick();
        check("held_drain", 32'(busy[1]), 32'd0);

        run(2, 63, 2'd3);

        check("sb_left", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
